// File: rtl/wide_spm_preload_pkg.sv
// Shared types and constants for the wide SPM preload path.
package wide_spm_preload_pkg;
  localparam int SPM_WORD_BYTES = 64;
  localparam int SPM_WORD_W     = SPM_WORD_BYTES * 8;

  typedef logic [SPM_WORD_W-1:0]     wide_word_t;
  typedef logic [SPM_WORD_BYTES-1:0] wide_be_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } preload_state_e;
endpackage

// File: rtl/wide_spm_byte_packer.sv
// Packs bytes little-endian into one SRAM word, tracking which lanes hold data.
module wide_spm_byte_packer #(
  parameter int WordBytes = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   accept_i,
  input  logic [7:0]             byte_i,
  input  logic                   flush_i,
  input  logic                   clear_i,
  output logic                   full_o,
  output logic                   partial_o,
  output logic [WordBytes*8-1:0] data_o,
  output logic [WordBytes-1:0]   be_o
);
  localparam int CntW = $clog2(WordBytes + 1);

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WordBytes*8-1:0] data_q, data_d;
  logic [WordBytes-1:0]   be_q, be_d;

  assign full_o    = accept_i && (cnt_q == CntW'(WordBytes - 1));
  // A byte landing in the same cycle as the flush counts toward the partial word.
  assign partial_o = flush_i && ((cnt_q != '0) || accept_i);
  assign data_o    = data_q;
  assign be_o      = be_q;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    be_d   = be_q;
    if (clear_i) begin
      cnt_d  = '0;
      data_d = '0;
      be_d   = '0;
    end else if (accept_i) begin
      cnt_d = cnt_q + 1'b1;
      for (int k = 0; k < WordBytes; k++) begin
        if (cnt_q == CntW'(k)) begin
          data_d[k*8 +: 8] = byte_i;
          be_d[k]          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      be_q   <= be_d;
    end
  end
endmodule

// File: rtl/wide_spm_preload_ctrl.sv
// Sequences byte-stream preload of the wide SPM: fill a word, write it, advance address.
module wide_spm_preload_ctrl
  import wide_spm_preload_pkg::*;
#(
  parameter int SramDepth = 16384,
  parameter int WordBytes = SPM_WORD_BYTES,
  parameter int AddrWidth = $clog2(SramDepth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic [AddrWidth:0]     num_words_i,
  input  logic                   flush_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  output logic                   byte_ready_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [WordBytes*8-1:0] mem_wdata_o,
  output logic [WordBytes-1:0]   mem_be_o,
  input  logic                   mem_gnt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   wrapped_o
);
  preload_state_e       state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth:0]   num_q, num_d, wcnt_q, wcnt_d;
  logic                 wrapped_q, wrapped_d;
  logic                 accept, pk_full, pk_partial, pk_clear;

  assign accept = byte_valid_i && byte_ready_o;

  wide_spm_byte_packer #(.WordBytes(WordBytes)) u_packer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .accept_i  (accept),
    .byte_i    (byte_i),
    .flush_i   (flush_i),
    .clear_i   (pk_clear),
    .full_o    (pk_full),
    .partial_o (pk_partial),
    .data_o    (mem_wdata_o),
    .be_o      (mem_be_o)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    num_d        = num_q;
    wcnt_d       = wcnt_q;
    wrapped_d    = wrapped_q;
    byte_ready_o = 1'b0;
    mem_req_o    = 1'b0;
    done_o       = 1'b0;
    pk_clear     = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        addr_d    = base_addr_i;
        num_d     = num_words_i;
        wcnt_d    = '0;
        wrapped_d = 1'b0;
        state_d   = (num_words_i == '0) ? DONE : FILL;
      end
      FILL: begin
        byte_ready_o = 1'b1;
        if (pk_full || pk_partial) state_d = WRITE;
      end
      WRITE: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          pk_clear = 1'b1;
          // Explicit compare keeps non-power-of-two depths correct.
          if (addr_q == AddrWidth'(SramDepth - 1)) begin
            addr_d    = '0;
            wrapped_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          wcnt_d  = wcnt_q + 1'b1;
          state_d = (wcnt_d == num_q) ? DONE : FILL;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      num_q     <= '0;
      wcnt_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      num_q     <= num_d;
      wcnt_q    <= wcnt_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign mem_we_o   = mem_req_o;
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != IDLE);
  assign wrapped_o  = wrapped_q;
endmodule
